seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the ALU's combinational multiplier.
- Sits beside the ALU in the CPU datapath and serves the DIV/REM opcodes.
- Stalls the CPU through BUSYWAIT, using the same handshake style as the data memory.
- Produces one quotient bit per clock.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  request pulse; sampled only in IDLE or DONE state.
DIVIDEND  input  WIDTH  unsigned dividend; sampled on the accepting edge.
DIVISOR  input  WIDTH  unsigned divisor; sampled on the accepting edge.
BUSYWAIT  output  1  high while a division is in progress (CPU stall).
DONE  output  1  one-cycle pulse; results valid.
QUOTIENT  output  WIDTH  registered quotient.
REMAINDER  output  WIDTH  registered remainder.
DIV_BY_ZERO  output  1  set with DONE when DIVISOR was 0; held with the results.

Behaviour:
- Reset: on a RESET-high edge, state=IDLE and all outputs are 0 (BUSYWAIT, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO). Internal registers, including the iteration counter, are cleared.
- RESET has priority over everything; RESET mid-CALC aborts with no DONE.
- States: IDLE, CALC, DONE.
- IDLE or DONE with START=1 at edge N:
  - Latch DIVIDEND and DIVISOR.
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - DONE=0.
  - DIVISOR!=0: go to CALC with BUSYWAIT=1.
  - DIVISOR==0: go straight to DONE at edge N with BUSYWAIT=0, QUOTIENT={WIDTH{1}}, REMAINDER=DIVIDEND, DIV_BY_ZERO=1, DONE=1.
- IDLE with START=0: hold state; outputs unchanged.
- DONE with START=0: go to IDLE at the next edge, DONE=0. QUOTIENT, REMAINDER and DIV_BY_ZERO hold.
- CALC, per edge (restoring step):
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor from the partial remainder (WIDTH+1-bit arithmetic).
  - If non-negative: keep the difference and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Increment the counter.
- CALC exit: on the WIDTH-th CALC edge (N+WIDTH):
  - State=DONE, BUSYWAIT=0, DONE=1, DIV_BY_ZERO=0.
  - QUOTIENT and REMAINDER load the final values.
- Latency: a valid divide accepted at edge N gives results and DONE visible after edge N+WIDTH (8 cycles at default).
- BUSYWAIT is high after edges N..N+WIDTH-1 exactly.
- START while in CALC is ignored; the latched operands are not disturbed.
- Back-to-back: START asserted in the DONE cycle is accepted at that edge.
- QUOTIENT and REMAINDER change only on completion (or reset). They never show intermediate values.
- Invariant: QUOTIENT*DIVISOR+REMAINDER==DIVIDEND and REMAINDER<DIVISOR for DIVISOR!=0.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset then START with 100/7 -> BUSYWAIT high 8 cycles; DONE pulse at edge N+8; QUOTIENT=14, REMAINDER=2, DIV_BY_ZERO=0.
2. START with 5/0 -> at edge N: DONE=1, DIV_BY_ZERO=1, QUOTIENT=255, REMAINDER=5, BUSYWAIT never high.
3. Edge cases, each a separate divide:
   - 255/1 -> Q=255, R=0.
   - 3/10 -> Q=0, R=3.
   - 200/200 -> Q=1, R=0.
   - 0/9 -> Q=0, R=0.
4. Start 100/7, re-pulse START with 50/5 at cycle N+3 -> ignored; result Q=14, R=2 at N+8.
5. Start 100/7, assert RESET at N+4 -> next edge: IDLE, all outputs 0, no DONE. Then 9/4 completes with Q=2, R=1.
6. Back-to-back: START 100/7, then START 77/8 in the DONE cycle -> second DONE 8 edges later with Q=9, R=5. First results hold until then.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One quotient bit per clock; BUSYWAIT stalls the CPU while a divide runs,
// and DONE pulses for one cycle when QUOTIENT/REMAINDER/DIV_BY_ZERO update.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSYWAIT,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_BY_ZERO
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           next_state;

  // Dividend register: shifts out dividend bits at the top and collects
  // quotient bits at the bottom, so it holds the quotient after WIDTH steps.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  // The partial remainder is always below the divisor between steps, so
  // only WIDTH bits need storing; the trial subtraction uses WIDTH+1 bits.
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last_step;
  logic             divisor_zero;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH:0]   dvd_ext;
  logic [WIDTH-1:0] dvd_step;

  assign divisor_zero = (DIVISOR == '0);

  // One restoring step: shift, trial-subtract, keep or restore.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    // A negative trial difference always has its top bit set, since the
    // shifted remainder is strictly less than twice the divisor.
    qbit     = ~diff[WIDTH];
    rem_step = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_ext  = {dvd_q, qbit};
    dvd_step = dvd_ext[WIDTH-1:0];
  end

  // Next-state logic; START is only honoured in IDLE and DONE.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    next_state = state_q;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          accept     = 1'b1;
          next_state = divisor_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == LAST_STEP) begin
          last_step  = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (START) begin
          accept     = 1'b1;
          next_state = divisor_zero ? S_DONE : S_CALC;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Working registers: load on accept, iterate while in CALC.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      dvd_q <= DIVIDEND;
      dvs_q <= DIVISOR;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_CALC) begin
      dvd_q <= dvd_step;
      rem_q <= rem_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered outputs; results change only on completion or reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BUSYWAIT    <= 1'b0;
      DONE        <= 1'b0;
      QUOTIENT    <= '0;
      REMAINDER   <= '0;
      DIV_BY_ZERO <= 1'b0;
    end else if (accept) begin
      if (divisor_zero) begin
        BUSYWAIT    <= 1'b0;
        DONE        <= 1'b1;
        QUOTIENT    <= '1;
        REMAINDER   <= DIVIDEND;
        DIV_BY_ZERO <= 1'b1;
      end else begin
        BUSYWAIT    <= 1'b1;
        DONE        <= 1'b0;
      end
    end else if (last_step) begin
      BUSYWAIT    <= 1'b0;
      DONE        <= 1'b1;
      QUOTIENT    <= dvd_step;
      REMAINDER   <= rem_step;
      DIV_BY_ZERO <= 1'b0;
    end else if (state_q == S_DONE) begin
      DONE <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed tests for seq_divider with a cycle-level
// arithmetic model checked every cycle plus hand-computed expectations.
module tb_seq_divider;

  localparam int W = 8;

  logic         CLK;
  logic         RESET;
  logic         START;
  logic [W-1:0] DIVIDEND;
  logic [W-1:0] DIVISOR;
  logic         BUSYWAIT;
  logic         DONE;
  logic [W-1:0] QUOTIENT;
  logic [W-1:0] REMAINDER;
  logic         DIV_BY_ZERO;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .DIVIDEND   (DIVIDEND),
    .DIVISOR    (DIVISOR),
    .BUSYWAIT   (BUSYWAIT),
    .DONE       (DONE),
    .QUOTIENT   (QUOTIENT),
    .REMAINDER  (REMAINDER),
    .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a divide takes W edges, then results are a/b and a%b.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_r    = '0;
  logic         m_dbz  = 1'b0;
  logic [W-1:0] m_a    = '0;
  logic [W-1:0] m_b    = '0;
  int           m_left = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_q    <= m_a / m_b;
        m_r    <= m_a % m_b;
        m_dbz  <= 1'b0;
      end
    end else if (START) begin
      if (DIVISOR == 0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_q    <= '1;
        m_r    <= DIVIDEND;
        m_dbz  <= 1'b1;
      end else begin
        m_a    <= DIVIDEND;
        m_b    <= DIVISOR;
        m_left <= W;
        m_busy <= 1'b1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("busywait",    BUSYWAIT,    m_busy);
      check("done",        DONE,        m_done);
      check("quotient",    QUOTIENT,    m_q);
      check("remainder",   REMAINDER,   m_r);
      check("div_by_zero", DIV_BY_ZERO, m_dbz);
    end
  end

  // Present a START pulse; caller is at a negedge, returns at the negedge
  // right after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    START    = 1'b1;
    DIVIDEND = a;
    DIVISOR  = b;
    @(negedge CLK);
    START    = 1'b0;
  endtask

  // Wait (bounded) for DONE, counting cycles and cycles with BUSYWAIT high.
  task automatic wait_done(output int cyc, output int busy);
    cyc  = 0;
    busy = 0;
    while (DONE !== 1'b1 && cyc < 40) begin
      if (BUSYWAIT === 1'b1) busy++;
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= 40) check("done_timeout", DONE, 1);
  endtask

  logic [W-1:0] ea [4] = '{8'd255, 8'd3,  8'd200, 8'd0};
  logic [W-1:0] eb [4] = '{8'd1,   8'd10, 8'd200, 8'd9};
  logic [W-1:0] eq [4] = '{8'd255, 8'd0,  8'd1,   8'd0};
  logic [W-1:0] er [4] = '{8'd0,   8'd3,  8'd0,   8'd0};

  initial begin
    int cyc;
    int busy;
    RESET    = 1'b1;
    START    = 1'b0;
    DIVIDEND = '0;
    DIVISOR  = '0;
    repeat (2) @(negedge CLK);
    check("reset_busywait",    BUSYWAIT,    0);
    check("reset_done",        DONE,        0);
    check("reset_quotient",    QUOTIENT,    0);
    check("reset_remainder",   REMAINDER,   0);
    check("reset_div_by_zero", DIV_BY_ZERO, 0);
    RESET  = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);

    // 1: 100/7 with latency and busy-window checks.
    launch(8'd100, 8'd7);
    wait_done(cyc, busy);
    check("t1_latency", cyc, 8);
    check("t1_busy_cycles", busy, 8);
    check("t1_quotient", QUOTIENT, 14);
    check("t1_remainder", REMAINDER, 2);
    check("t1_dbz", DIV_BY_ZERO, 0);
    @(negedge CLK);

    // 2: divide by zero completes at the accepting edge.
    launch(8'd5, 8'd0);
    check("t2_done", DONE, 1);
    check("t2_dbz", DIV_BY_ZERO, 1);
    check("t2_quotient", QUOTIENT, 255);
    check("t2_remainder", REMAINDER, 5);
    check("t2_busywait", BUSYWAIT, 0);
    @(negedge CLK);
    check("t2_dbz_held", DIV_BY_ZERO, 1);
    check("t2_done_drop", DONE, 0);

    // 3: edge cases.
    for (int i = 0; i < 4; i++) begin
      launch(ea[i], eb[i]);
      wait_done(cyc, busy);
      check($sformatf("t3_q_%0d_%0d", ea[i], eb[i]), QUOTIENT, eq[i]);
      check($sformatf("t3_r_%0d_%0d", ea[i], eb[i]), REMAINDER, er[i]);
      @(negedge CLK);
    end

    // 4: START during CALC is ignored.
    launch(8'd100, 8'd7);
    repeat (2) @(negedge CLK);
    launch(8'd50, 8'd5);
    wait_done(cyc, busy);
    check("t4_latency_rest", cyc, 5);
    check("t4_quotient", QUOTIENT, 14);
    check("t4_remainder", REMAINDER, 2);
    @(negedge CLK);

    // 5: reset mid-CALC aborts, then a fresh divide.
    launch(8'd100, 8'd7);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("t5_busywait", BUSYWAIT, 0);
    check("t5_done", DONE, 0);
    check("t5_quotient", QUOTIENT, 0);
    check("t5_remainder", REMAINDER, 0);
    repeat (10) @(negedge CLK);
    launch(8'd9, 8'd4);
    wait_done(cyc, busy);
    check("t5_quotient_after", QUOTIENT, 2);
    check("t5_remainder_after", REMAINDER, 1);
    @(negedge CLK);

    // 6: back-to-back, second START in the DONE cycle.
    launch(8'd100, 8'd7);
    wait_done(cyc, busy);
    launch(8'd77, 8'd8);
    check("t6_busy_second", BUSYWAIT, 1);
    check("t6_q_hold", QUOTIENT, 14);
    check("t6_r_hold", REMAINDER, 2);
    wait_done(cyc, busy);
    check("t6_latency", cyc, 8);
    check("t6_quotient", QUOTIENT, 9);
    check("t6_remainder", REMAINDER, 5);

    repeat (3) @(negedge CLK);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
